// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
// Control-flow redirection sequencer for a 5-stage core with static
// not-taken prediction. When EX resolves a taken branch or jump, the
// wrong-path IF/ID and ID/EX contents are killed and the target PC is
// offered to fetch over a valid/ready channel. The front end is held
// until fetch accepts. A taken target that is not 4-byte aligned raises
// a one-cycle misalignment pulse instead of redirecting.
//
// Optional feature macro: BR_PERF_CNT_EN
//   defined   -> saturating resolve/redirect performance counters
//   undefined -> no counter flops, o_br_cnt/o_taken_cnt tied to zero
module branch_redirect_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ex_valid,
    input  logic             i_ex_branch,
    input  logic             i_ex_jump,
    input  logic             i_ex_br_taken,
    input  logic [XLEN-1:0]  i_ex_target,
    input  logic             i_redir_ready,
    output logic             o_redir_valid,
    output logic [XLEN-1:0]  o_redir_pc,
    output logic             o_flush_if_id,
    output logic             o_flush_id_ex,
    output logic             o_stall_front,
    output logic             o_misalign_exc,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_taken_cnt
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [XLEN-1:0]   r_redir_pc;
    logic              r_misalign_exc;

    logic              w_resolve;
    logic              w_taken;
    logic [XLEN-1:0]   w_tgt;
    logic              w_misaligned;
    logic              w_redir_load;
    logic              w_misalign_set;
    logic              w_resolve_idle;

    // A jump flag always wins over the comparator result, so an instruction
    // marked both branch and jump is handled as an unconditional jump.
    assign w_resolve    = i_ex_valid & (i_ex_branch | i_ex_jump);
    assign w_taken      = w_resolve & (i_ex_jump | i_ex_br_taken);
    assign w_tgt        = {i_ex_target[XLEN-1:1], 1'b0};
    assign w_misaligned = w_tgt[1];

    // Next-state and per-cycle pipeline control decode.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        w_next_state   = r_state;
        o_flush_if_id  = 1'b0;
        o_flush_id_ex  = 1'b0;
        o_stall_front  = 1'b0;
        w_redir_load   = 1'b0;
        w_misalign_set = 1'b0;
        w_resolve_idle = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_resolve_idle = w_resolve;
                if (w_taken && !w_misaligned) begin
                    o_flush_if_id = 1'b1;
                    o_flush_id_ex = 1'b1;
                    w_redir_load  = 1'b1;
                    w_next_state  = REDIR;
                end else if (w_taken) begin
                    w_misalign_set = 1'b1;
                end
            end
            REDIR: begin
                // EX holds a flushed bubble here, so ex_* inputs are ignored.
                o_flush_if_id = 1'b1;
                o_stall_front = 1'b1;
                if (i_redir_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State, redirect PC capture and registered misalignment pulse.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, sampled only on the rising edge; state
        // updates use non-blocking assignments so all flops see pre-edge values.
        if (!rst_n) begin
            r_state        <= IDLE;
            r_redir_pc     <= '0;
            r_misalign_exc <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_misalign_exc <= w_misalign_set;
            // PC is only loaded on entry, so it stays stable for the whole handshake.
            if (w_redir_load) begin
                r_redir_pc <= w_tgt;
            end
        end
    end

    assign o_redir_valid  = (r_state == REDIR);
    assign o_redir_pc     = r_redir_pc;
    assign o_misalign_exc = r_misalign_exc;

`ifdef BR_PERF_CNT_EN
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    // Saturating counters: resolves seen in IDLE and entries into REDIR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
        end else begin
            if (w_resolve_idle && (r_br_cnt != {CNT_W{1'b1}})) begin
                r_br_cnt <= r_br_cnt + 1'b1;
            end
            if (w_redir_load && (r_taken_cnt != {CNT_W{1'b1}})) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
        end
    end

    assign o_br_cnt    = r_br_cnt;
    assign o_taken_cnt = r_taken_cnt;
`else
    logic w_unused_resolve_idle;
    assign w_unused_resolve_idle = w_resolve_idle;
    assign o_br_cnt    = '0;
    assign o_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed testbench for branch_redirect_ctrl. Inputs change 1 time unit
// after a rising edge; outputs are sampled 1 time unit later, mid-cycle.
module tb_branch_redirect_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             ex_valid;
    logic             ex_branch;
    logic             ex_jump;
    logic             ex_br_taken;
    logic [XLEN-1:0]  ex_target;
    logic             redir_ready;
    logic             redir_valid;
    logic [XLEN-1:0]  redir_pc;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             stall_front;
    logic             misalign_exc;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;

    int n_vec;
    int n_err;

    branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_ex_valid     (ex_valid),
        .i_ex_branch    (ex_branch),
        .i_ex_jump      (ex_jump),
        .i_ex_br_taken  (ex_br_taken),
        .i_ex_target    (ex_target),
        .i_redir_ready  (redir_ready),
        .o_redir_valid  (redir_valid),
        .o_redir_pc     (redir_pc),
        .o_flush_if_id  (flush_if_id),
        .o_flush_id_ex  (flush_id_ex),
        .o_stall_front  (stall_front),
        .o_misalign_exc (misalign_exc),
        .o_br_cnt       (br_cnt),
        .o_taken_cnt    (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid    = 1'b0;
        ex_branch   = 1'b0;
        ex_jump     = 1'b0;
        ex_br_taken = 1'b0;
        ex_target   = '0;
    endtask

    task automatic drive_ex(input logic br, input logic jmp, input logic tk,
                            input logic [XLEN-1:0] tgt);
        ex_valid    = 1'b1;
        ex_branch   = br;
        ex_jump     = jmp;
        ex_br_taken = tk;
        ex_target   = tgt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_ex();
        redir_ready = 1'b0;
        tick();
        tick();
        #1;
        n_vec++; if (redir_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", redir_valid); end
        n_vec++; if (redir_pc !== '0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", redir_pc); end
        n_vec++; if ({flush_if_id, flush_id_ex, stall_front, misalign_exc} !== 4'b0) begin n_err++; $display("FAIL reset_ctrl got=%b exp=0000", {flush_if_id, flush_id_ex, stall_front, misalign_exc}); end
        n_vec++; if ({br_cnt, taken_cnt} !== '0) begin n_err++; $display("FAIL reset_cnt got=%h/%h exp=0/0", br_cnt, taken_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    // beq not taken; ready asserted while IDLE must be ignored.
    task automatic test_not_taken();
        drive_ex(1'b1, 1'b0, 1'b0, 32'h40);
        redir_ready = 1'b1;
        #1;
        n_vec++; if ({flush_if_id, flush_id_ex, stall_front} !== 3'b0) begin n_err++; $display("FAIL nt_ctrl got=%b exp=000", {flush_if_id, flush_id_ex, stall_front}); end
        tick();
        clear_ex();
        redir_ready = 1'b0;
        #1;
        n_vec++; if (redir_valid !== 1'b0) begin n_err++; $display("FAIL nt_valid got=%b exp=0", redir_valid); end
        n_vec++; if (misalign_exc !== 1'b0) begin n_err++; $display("FAIL nt_misalign got=%b exp=0", misalign_exc); end
        tick();
    endtask

    // bne taken to 0x40, fetch ready in the first REDIR cycle.
    task automatic test_taken();
        drive_ex(1'b1, 1'b0, 1'b1, 32'h40);
        #1;
        n_vec++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin n_err++; $display("FAIL tk_flush_T got=%b exp=11", {flush_if_id, flush_id_ex}); end
        n_vec++; if ({redir_valid, stall_front} !== 2'b00) begin n_err++; $display("FAIL tk_valid_T got=%b exp=00", {redir_valid, stall_front}); end
        tick();
        clear_ex();
        redir_ready = 1'b1;
        #1;
        n_vec++; if (redir_valid !== 1'b1) begin n_err++; $display("FAIL tk_valid_T1 got=%b exp=1", redir_valid); end
        n_vec++; if (redir_pc !== 32'h40) begin n_err++; $display("FAIL tk_pc got=%h exp=00000040", redir_pc); end
        n_vec++; if ({stall_front, flush_if_id, flush_id_ex} !== 3'b110) begin n_err++; $display("FAIL tk_ctrl_T1 got=%b exp=110", {stall_front, flush_if_id, flush_id_ex}); end
        tick();
        redir_ready = 1'b0;
        #1;
        n_vec++; if ({redir_valid, stall_front, flush_if_id} !== 3'b000) begin n_err++; $display("FAIL tk_done_T2 got=%b exp=000", {redir_valid, stall_front, flush_if_id}); end
        tick();
    endtask

    // jalr to 0x103: cleared bit0 gives 0x102, bit1 set -> misaligned.
    task automatic test_misalign();
        drive_ex(1'b0, 1'b1, 1'b0, 32'h103);
        #1;
        n_vec++; if ({flush_if_id, flush_id_ex} !== 2'b00) begin n_err++; $display("FAIL mis_flush got=%b exp=00", {flush_if_id, flush_id_ex}); end
        tick();
        clear_ex();
        #1;
        n_vec++; if (misalign_exc !== 1'b1) begin n_err++; $display("FAIL mis_pulse_T1 got=%b exp=1", misalign_exc); end
        n_vec++; if (redir_valid !== 1'b0) begin n_err++; $display("FAIL mis_valid got=%b exp=0", redir_valid); end
        tick();
        #1;
        n_vec++; if (misalign_exc !== 1'b0) begin n_err++; $display("FAIL mis_pulse_T2 got=%b exp=0", misalign_exc); end
        tick();
    endtask

    // jalr to 0x101 -> 0x100, fetch stalls 3 cycles; EX activity in REDIR ignored.
    task automatic test_hold();
        drive_ex(1'b0, 1'b1, 1'b0, 32'h101);
        redir_ready = 1'b0;
        #1;
        n_vec++; if (flush_id_ex !== 1'b1) begin n_err++; $display("FAIL hold_flush_T got=%b exp=1", flush_id_ex); end
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                clear_ex();
                redir_ready = 1'b1;
            end else begin
                drive_ex(1'b0, 1'b1, 1'b0, 32'h300);
            end
            #1;
            n_vec++; if (redir_pc !== 32'h100) begin n_err++; $display("FAIL hold_pc c%0d got=%h exp=00000100", i, redir_pc); end
            n_vec++; if ({redir_valid, stall_front, flush_if_id, flush_id_ex} !== 4'b1110) begin n_err++; $display("FAIL hold_ctrl c%0d got=%b exp=1110", i, {redir_valid, stall_front, flush_if_id, flush_id_ex}); end
            tick();
        end
        redir_ready = 1'b0;
        #1;
        n_vec++; if ({redir_valid, stall_front, flush_if_id} !== 3'b000) begin n_err++; $display("FAIL hold_done got=%b exp=000", {redir_valid, stall_front, flush_if_id}); end
        tick();
    endtask

    // Reset in the second REDIR cycle drops the request.
    task automatic test_reset_in_redir();
        drive_ex(1'b0, 1'b1, 1'b0, 32'h80);
        tick();
        clear_ex();
        tick();
        #1;
        n_vec++; if (redir_valid !== 1'b1) begin n_err++; $display("FAIL rr_pre got=%b exp=1", redir_valid); end
        rst_n = 1'b0;
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        #1;
        n_vec++; if ({redir_valid, stall_front, flush_if_id} !== 3'b000) begin n_err++; $display("FAIL rr_drop got=%b exp=000", {redir_valid, stall_front, flush_if_id}); end
        n_vec++; if (redir_pc !== '0) begin n_err++; $display("FAIL rr_pc got=%h exp=0", redir_pc); end
        n_vec++; if ({br_cnt, taken_cnt} !== '0) begin n_err++; $display("FAIL rr_cnt got=%h/%h exp=0/0", br_cnt, taken_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    // branch and jump both set with comparator false -> taken as jump.
    task automatic test_both_flags();
        drive_ex(1'b1, 1'b1, 1'b0, 32'h200);
        #1;
        n_vec++; if (flush_id_ex !== 1'b1) begin n_err++; $display("FAIL both_flush got=%b exp=1", flush_id_ex); end
        tick();
        clear_ex();
        redir_ready = 1'b1;
        #1;
        n_vec++; if ({redir_valid, redir_pc} !== {1'b1, 32'h200}) begin n_err++; $display("FAIL both_redir got=%b/%h exp=1/00000200", redir_valid, redir_pc); end
        tick();
        redir_ready = 1'b0;
        #1;
        n_vec++; if (redir_valid !== 1'b0) begin n_err++; $display("FAIL both_done got=%b exp=0", redir_valid); end
        tick();
    endtask

    // Back-to-back taken branches with immediate ready; counters and saturation.
    task automatic test_back_to_back();
        logic [CNT_W-1:0] exp_br;
        logic [CNT_W-1:0] exp_tk;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_ex(1'b1, 1'b0, 1'b1, 32'h1000 + 32'(i * 16));
            tick();
            clear_ex();
            redir_ready = 1'b1;
            #1;
            n_vec++; if (redir_pc !== 32'h1000 + 32'(i * 16)) begin n_err++; $display("FAIL b2b_pc i%0d got=%h exp=%h", i, redir_pc, 32'h1000 + 32'(i * 16)); end
            tick();
            redir_ready = 1'b0;
        end
        drive_ex(1'b1, 1'b0, 1'b0, 32'h40);
        tick();
        clear_ex();
`ifdef BR_PERF_CNT_EN
        exp_br = 4'd4;
        exp_tk = 4'd3;
`else
        exp_br = 4'd0;
        exp_tk = 4'd0;
`endif
        #1;
        n_vec++; if ({br_cnt, taken_cnt} !== {exp_br, exp_tk}) begin n_err++; $display("FAIL cnt_mid got=%0d/%0d exp=%0d/%0d", br_cnt, taken_cnt, exp_br, exp_tk); end
        for (int i = 0; i < 20; i++) begin
            drive_ex(1'b1, 1'b0, 1'b1, 32'h40);
            tick();
            clear_ex();
            redir_ready = 1'b1;
            tick();
            redir_ready = 1'b0;
        end
`ifdef BR_PERF_CNT_EN
        exp_br = 4'd15;
        exp_tk = 4'd15;
`endif
        #1;
        n_vec++; if ({br_cnt, taken_cnt} !== {exp_br, exp_tk}) begin n_err++; $display("FAIL cnt_sat got=%0d/%0d exp=%0d/%0d", br_cnt, taken_cnt, exp_br, exp_tk); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_not_taken();
        test_taken();
        test_misalign();
        test_hold();
        test_reset_in_redir();
        test_both_flags();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
